// File: rtl/vproc_pkg.sv
// vproc_pkg: shared types and constants for the vector micro-op splitter
package vproc_pkg;

  localparam int UOP_OP_W   = 32;
  localparam int UOP_VREG_W = 5;
  localparam int UOP_IDX_W  = 3;
  localparam int NUM_VREGS  = 32;

  typedef enum logic [1:0] {EMUL_1, EMUL_2, EMUL_4, EMUL_8} emul_e;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  typedef struct packed {
    logic [UOP_OP_W-1:0]   op;
    logic [UOP_VREG_W-1:0] vd;
    logic [UOP_VREG_W-1:0] vs1;
    logic [UOP_VREG_W-1:0] vs2;
    logic [UOP_IDX_W-1:0]  idx;
    logic                  first;
    logic                  last;
  } uop_t;

  localparam uop_t UOP_RST = '{op: '0, vd: '0, vs1: '0, vs2: '0, idx: '0, first: 1'b1, last: 1'b0};

  // Index of the final micro-op for a given log2 EMUL (0, 1, 3 or 7).
  function automatic logic [UOP_IDX_W-1:0] last_idx(input emul_e e);
    return UOP_IDX_W'((4'd1 << e) - 4'd1);
  endfunction

endpackage

// File: rtl/vproc_uop_split.sv
// vproc_uop_split: splits queued vector instructions into register-granular micro-ops
module vproc_uop_split
  import vproc_pkg::*;
#(
  parameter int OP_W   = UOP_OP_W,
  parameter int VREG_W = UOP_VREG_W
) (
  input  logic              clk_i,
  input  logic              async_rst_ni,
  input  logic              flush_i,
  output logic              instr_ready_o,
  input  logic              instr_valid_i,
  input  logic [OP_W-1:0]   instr_op_i,
  input  logic [1:0]        instr_emul_i,
  input  logic [VREG_W-1:0] instr_vd_i,
  input  logic [VREG_W-1:0] instr_vs1_i,
  input  logic [VREG_W-1:0] instr_vs2_i,
  output logic              uop_valid_o,
  input  logic              uop_ready_i,
  output logic [OP_W-1:0]   uop_op_o,
  output logic [VREG_W-1:0] uop_vd_o,
  output logic [VREG_W-1:0] uop_vs1_o,
  output logic [VREG_W-1:0] uop_vs2_o,
  output logic [2:0]        uop_idx_o,
  output logic              uop_first_o,
  output logic              uop_last_o,
  output logic              busy_o
);

  state_e r_state, w_state_nxt;
  uop_t   r_uop, w_uop_nxt;
  emul_e  r_emul, w_emul_nxt;
  logic   w_uop_valid;
  logic   w_uop_hs;
  logic   w_instr_hs;

  assign w_uop_valid   = r_state == S_ISSUE;
  assign w_uop_hs      = w_uop_valid & uop_ready_i;
  assign instr_ready_o = ~flush_i & (~w_uop_valid | (w_uop_hs & r_uop.last));
  assign w_instr_hs    = instr_valid_i & instr_ready_o;

  // Next state: flush wins, then a new pop (also covers back-to-back), then stepping through registers.
  always_comb begin
    w_state_nxt = r_state;
    w_uop_nxt   = r_uop;
    w_emul_nxt  = r_emul;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
      w_uop_nxt   = UOP_RST;
    end else if (w_instr_hs) begin
      w_state_nxt     = S_ISSUE;
      w_emul_nxt      = emul_e'(instr_emul_i);
      w_uop_nxt.op    = instr_op_i;
      w_uop_nxt.vd    = instr_vd_i;
      w_uop_nxt.vs1   = instr_vs1_i;
      w_uop_nxt.vs2   = instr_vs2_i;
      w_uop_nxt.idx   = '0;
      w_uop_nxt.first = 1'b1;
      w_uop_nxt.last  = emul_e'(instr_emul_i) == EMUL_1;
    end else if (w_uop_hs) begin
      w_state_nxt     = r_uop.last ? S_IDLE : S_ISSUE;
      w_uop_nxt.vd    = r_uop.last ? r_uop.vd  : r_uop.vd  + UOP_VREG_W'(1);
      w_uop_nxt.vs1   = r_uop.last ? r_uop.vs1 : r_uop.vs1 + UOP_VREG_W'(1);
      w_uop_nxt.vs2   = r_uop.last ? r_uop.vs2 : r_uop.vs2 + UOP_VREG_W'(1);
      w_uop_nxt.idx   = r_uop.last ? r_uop.idx : r_uop.idx + UOP_IDX_W'(1);
      w_uop_nxt.first = r_uop.last & r_uop.first;
      w_uop_nxt.last  = r_uop.last | (r_uop.idx + UOP_IDX_W'(1) == last_idx(r_emul));
    end
  end

  // State, latched instruction fields and current micro-op.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_state <= S_IDLE;
      r_uop   <= UOP_RST;
      r_emul  <= EMUL_1;
    end else begin
      r_state <= w_state_nxt;
      r_uop   <= w_uop_nxt;
      r_emul  <= w_emul_nxt;
    end
  end

  assign uop_valid_o = w_uop_valid;
  assign busy_o      = w_uop_valid;
  assign uop_op_o    = r_uop.op;
  assign uop_vd_o    = r_uop.vd;
  assign uop_vs1_o   = r_uop.vs1;
  assign uop_vs2_o   = r_uop.vs2;
  assign uop_idx_o   = r_uop.idx;
  assign uop_first_o = r_uop.first;
  assign uop_last_o  = r_uop.last;

endmodule

// File: tb/tb_vproc_uop_split.sv
// tb_vproc_uop_split: directed and randomized checks of the micro-op splitter
module tb_vproc_uop_split;

  logic        clk_i = 1'b0;
  logic        async_rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        instr_ready_o;
  logic        instr_valid_i = 1'b0;
  logic [31:0] instr_op_i = '0;
  logic [1:0]  instr_emul_i = '0;
  logic [4:0]  instr_vd_i = '0;
  logic [4:0]  instr_vs1_i = '0;
  logic [4:0]  instr_vs2_i = '0;
  logic        uop_valid_o;
  logic        uop_ready_i = 1'b0;
  logic [31:0] uop_op_o;
  logic [4:0]  uop_vd_o;
  logic [4:0]  uop_vs1_o;
  logic [4:0]  uop_vs2_o;
  logic [2:0]  uop_idx_o;
  logic        uop_first_o;
  logic        uop_last_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] op;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [2:0]  idx;
    logic        first;
    logic        last;
  } exp_t;

  exp_t sb[$];

  vproc_uop_split dut (
    .clk_i(clk_i), .async_rst_ni(async_rst_ni), .flush_i(flush_i),
    .instr_ready_o(instr_ready_o), .instr_valid_i(instr_valid_i), .instr_op_i(instr_op_i),
    .instr_emul_i(instr_emul_i), .instr_vd_i(instr_vd_i), .instr_vs1_i(instr_vs1_i),
    .instr_vs2_i(instr_vs2_i), .uop_valid_o(uop_valid_o), .uop_ready_i(uop_ready_i),
    .uop_op_o(uop_op_o), .uop_vd_o(uop_vd_o), .uop_vs1_o(uop_vs1_o), .uop_vs2_o(uop_vs2_o),
    .uop_idx_o(uop_idx_o), .uop_first_o(uop_first_o), .uop_last_o(uop_last_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc;
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive_instr(input logic [1:0] e, input logic [4:0] vd, input logic [4:0] vs1,
                             input logic [4:0] vs2, input logic [31:0] op);
    instr_valid_i = 1'b1;
    instr_emul_i  = e;
    instr_vd_i    = vd;
    instr_vs1_i   = vs1;
    instr_vs2_i   = vs2;
    instr_op_i    = op;
  endtask

  function automatic logic [4:0] wrap(input logic [4:0] b, input int k);
    return 5'((int'(b) + k) % 32);
  endfunction

  task automatic test_reset;
    async_rst_ni = 1'b0;
    cyc();
    checks++;
    if ({uop_valid_o, busy_o, uop_idx_o, uop_first_o, uop_last_o} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got v=%0b b=%0b idx=%0d f=%0b l=%0b, want 0 0 0 1 0", uop_valid_o, busy_o, uop_idx_o, uop_first_o, uop_last_o);
    end
    checks++;
    if ({uop_op_o, uop_vd_o, uop_vs1_o, uop_vs2_o} !== '0) begin
      errors++;
      $display("FAIL reset_payload got op=%h vd=%0d vs1=%0d vs2=%0d, want all 0", uop_op_o, uop_vd_o, uop_vs1_o, uop_vs2_o);
    end
    checks++;
    if (instr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %0b want 1", instr_ready_o);
    end
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_emul8;
    logic [31:0] op;
    op = $urandom;
    uop_ready_i = 1'b1;
    drive_instr(2'd3, 5'd3, 5'd10, 5'd20, op);
    #1;
    checks++;
    if (instr_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL emul8_pop got ready=%0b want 1", instr_ready_o);
    end
    cyc();
    instr_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if ({uop_valid_o, uop_idx_o, uop_vd_o, uop_vs1_o, uop_vs2_o, uop_first_o, uop_last_o, instr_ready_o, uop_op_o} !==
          {1'b1, 3'(k), 5'(3 + k), 5'(10 + k), 5'(20 + k), k == 0, k == 7, k == 7, op}) begin
        errors++;
        $display("FAIL emul8_uop%0d got v=%0b idx=%0d vd=%0d vs1=%0d vs2=%0d f=%0b l=%0b rdy=%0b op=%h, want 1 %0d %0d %0d %0d %0b %0b %0b %h",
                 k, uop_valid_o, uop_idx_o, uop_vd_o, uop_vs1_o, uop_vs2_o, uop_first_o, uop_last_o, instr_ready_o, uop_op_o,
                 k, 3 + k, 10 + k, 20 + k, k == 0, k == 7, k == 7, op);
      end
      cyc();
    end
    checks++;
    if (uop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL emul8_done got valid=%0b want 0", uop_valid_o);
    end
  endtask

  task automatic test_wrap;
    logic [4:0] s1, s2;
    s1 = 5'($urandom);
    s2 = 5'($urandom);
    uop_ready_i = 1'b1;
    drive_instr(2'd2, 5'd30, s1, s2, 32'hA5A5_0004);
    cyc();
    instr_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({uop_valid_o, uop_idx_o, uop_vd_o, uop_vs1_o, uop_vs2_o, uop_last_o} !==
          {1'b1, 3'(k), wrap(5'd30, k), wrap(s1, k), wrap(s2, k), wrap(5'd30, k) == 5'd1}) begin
        errors++;
        $display("FAIL wrap_uop%0d got v=%0b idx=%0d vd=%0d vs1=%0d vs2=%0d l=%0b, want 1 %0d %0d %0d %0d %0b",
                 k, uop_valid_o, uop_idx_o, uop_vd_o, uop_vs1_o, uop_vs2_o, uop_last_o,
                 k, wrap(5'd30, k), wrap(s1, k), wrap(s2, k), wrap(5'd30, k) == 5'd1);
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back;
    uop_ready_i = 1'b1;
    drive_instr(2'd1, 5'd5, 5'd6, 5'd7, 32'h1111_0001);
    cyc();
    drive_instr(2'd0, 5'd9, 5'd31, 5'd2, 32'h2222_0002);
    #1;
    checks++;
    if ({uop_valid_o, uop_idx_o, uop_vd_o, uop_first_o, uop_last_o, instr_ready_o, uop_op_o} !==
        {1'b1, 3'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h1111_0001}) begin
      errors++;
      $display("FAIL b2b_a0 got v=%0b idx=%0d vd=%0d f=%0b l=%0b rdy=%0b op=%h", uop_valid_o, uop_idx_o, uop_vd_o, uop_first_o, uop_last_o, instr_ready_o, uop_op_o);
    end
    cyc();
    checks++;
    if ({uop_valid_o, uop_idx_o, uop_vd_o, uop_vs1_o, uop_first_o, uop_last_o, instr_ready_o} !==
        {1'b1, 3'd1, 5'd6, 5'd7, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_a1 got v=%0b idx=%0d vd=%0d vs1=%0d f=%0b l=%0b rdy=%0b", uop_valid_o, uop_idx_o, uop_vd_o, uop_vs1_o, uop_first_o, uop_last_o, instr_ready_o);
    end
    cyc();
    instr_valid_i = 1'b0;
    #1;
    checks++;
    if ({uop_valid_o, uop_idx_o, uop_vd_o, uop_vs1_o, uop_vs2_o, uop_first_o, uop_last_o, uop_op_o} !==
        {1'b1, 3'd0, 5'd9, 5'd31, 5'd2, 1'b1, 1'b1, 32'h2222_0002}) begin
      errors++;
      $display("FAIL b2b_b0 got v=%0b idx=%0d vd=%0d vs1=%0d vs2=%0d f=%0b l=%0b op=%h", uop_valid_o, uop_idx_o, uop_vd_o, uop_vs1_o, uop_vs2_o, uop_first_o, uop_last_o, uop_op_o);
    end
    cyc();
    checks++;
    if (uop_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got valid=%0b want 0", uop_valid_o);
    end
  endtask

  task automatic test_stall;
    uop_ready_i = 1'b1;
    drive_instr(2'd1, 5'd14, 5'd15, 5'd16, 32'hCAFE_0003);
    cyc();
    instr_valid_i = 1'b0;
    uop_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({uop_valid_o, uop_idx_o, uop_vd_o, uop_vs1_o, uop_vs2_o, uop_first_o, uop_last_o, instr_ready_o, uop_op_o} !==
          {1'b1, 3'd0, 5'd14, 5'd15, 5'd16, 1'b1, 1'b0, 1'b0, 32'hCAFE_0003}) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%0b idx=%0d vd=%0d f=%0b l=%0b rdy=%0b op=%h", k, uop_valid_o, uop_idx_o, uop_vd_o, uop_first_o, uop_last_o, instr_ready_o, uop_op_o);
      end
      cyc();
    end
    uop_ready_i = 1'b1;
    cyc();
    checks++;
    if ({uop_valid_o, uop_idx_o, uop_vd_o, uop_first_o, uop_last_o} !== {1'b1, 3'd1, 5'd15, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL stall_release got v=%0b idx=%0d vd=%0d f=%0b l=%0b, want 1 1 15 0 1", uop_valid_o, uop_idx_o, uop_vd_o, uop_first_o, uop_last_o);
    end
    cyc();
  endtask

  task automatic test_flush;
    uop_ready_i = 1'b1;
    drive_instr(2'd3, 5'd12, 5'd0, 5'd1, 32'hF00D_0008);
    cyc();
    drive_instr(2'd0, 5'd7, 5'd8, 5'd9, 32'hBEEF_0001);
    cyc();
    cyc();
    flush_i = 1'b1;
    #1;
    checks++;
    if ({uop_valid_o, uop_idx_o, instr_ready_o} !== {1'b1, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL flush_cycle got v=%0b idx=%0d rdy=%0b, want 1 2 0", uop_valid_o, uop_idx_o, instr_ready_o);
    end
    cyc();
    flush_i = 1'b0;
    #1;
    checks++;
    if ({uop_valid_o, uop_idx_o, instr_ready_o} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL flush_after got v=%0b idx=%0d rdy=%0b, want 0 0 1", uop_valid_o, uop_idx_o, instr_ready_o);
    end
    cyc();
    instr_valid_i = 1'b0;
    checks++;
    if ({uop_valid_o, uop_idx_o, uop_vd_o, uop_first_o, uop_last_o, uop_op_o} !== {1'b1, 3'd0, 5'd7, 1'b1, 1'b1, 32'hBEEF_0001}) begin
      errors++;
      $display("FAIL flush_next got v=%0b idx=%0d vd=%0d f=%0b l=%0b op=%h", uop_valid_o, uop_idx_o, uop_vd_o, uop_first_o, uop_last_o, uop_op_o);
    end
    cyc();
  endtask

  task automatic test_async_reset;
    uop_ready_i = 1'b1;
    drive_instr(2'd2, 5'd0, 5'd4, 5'd8, 32'h0BAD_0004);
    cyc();
    instr_valid_i = 1'b0;
    cyc();
    #2;
    async_rst_ni = 1'b0;
    #1;
    checks++;
    if ({uop_valid_o, busy_o, uop_idx_o, uop_first_o} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL arst_immediate got v=%0b b=%0b idx=%0d f=%0b, want 0 0 0 1", uop_valid_o, busy_o, uop_idx_o, uop_first_o);
    end
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    cyc();
    drive_instr(2'd0, 5'd17, 5'd18, 5'd19, 32'h600D_0001);
    cyc();
    instr_valid_i = 1'b0;
    checks++;
    if ({uop_valid_o, uop_idx_o, uop_vd_o, uop_first_o, uop_last_o, uop_op_o} !== {1'b1, 3'd0, 5'd17, 1'b1, 1'b1, 32'h600D_0001}) begin
      errors++;
      $display("FAIL arst_newpop got v=%0b idx=%0d vd=%0d f=%0b l=%0b op=%h", uop_valid_o, uop_idx_o, uop_vd_o, uop_first_o, uop_last_o, uop_op_o);
    end
    cyc();
  endtask

  task automatic test_random;
    int   n_gen, n_cyc;
    logic exp_rdy;
    logic popped;
    exp_t u;
    n_gen = 0;
    n_cyc = 0;
    sb.delete();
    while (n_cyc < 4000 && (n_gen < 150 || instr_valid_i || sb.size() != 0)) begin
      if (!instr_valid_i && n_gen < 150 && $urandom_range(3) != 0) begin
        drive_instr(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
        n_gen++;
      end
      uop_ready_i = $urandom_range(9) < 7;
      #1;
      checks++;
      if (uop_valid_o !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL rand_valid cyc=%0d got %0b want %0b", n_cyc, uop_valid_o, sb.size() != 0);
      end
      if (sb.size() != 0) begin
        checks++;
        if ({uop_op_o, uop_vd_o, uop_vs1_o, uop_vs2_o, uop_idx_o, uop_first_o, uop_last_o} !==
            {sb[0].op, sb[0].vd, sb[0].vs1, sb[0].vs2, sb[0].idx, sb[0].first, sb[0].last}) begin
          errors++;
          $display("FAIL rand_uop cyc=%0d got op=%h vd=%0d vs1=%0d vs2=%0d idx=%0d f=%0b l=%0b want op=%h vd=%0d vs1=%0d vs2=%0d idx=%0d f=%0b l=%0b",
                   n_cyc, uop_op_o, uop_vd_o, uop_vs1_o, uop_vs2_o, uop_idx_o, uop_first_o, uop_last_o,
                   sb[0].op, sb[0].vd, sb[0].vs1, sb[0].vs2, sb[0].idx, sb[0].first, sb[0].last);
        end
      end
      exp_rdy = sb.size() == 0 || (sb.size() == 1 && uop_ready_i);
      checks++;
      if (instr_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready cyc=%0d got %0b want %0b", n_cyc, instr_ready_o, exp_rdy);
      end
      if (uop_valid_o && uop_ready_i && sb.size() != 0) void'(sb.pop_front());
      popped = instr_valid_i && instr_ready_o;
      if (popped) begin
        for (int i = 0; i < (1 << instr_emul_i); i++) begin
          u.op    = instr_op_i;
          u.vd    = wrap(instr_vd_i, i);
          u.vs1   = wrap(instr_vs1_i, i);
          u.vs2   = wrap(instr_vs2_i, i);
          u.idx   = 3'(i);
          u.first = i == 0;
          u.last  = i == (1 << instr_emul_i) - 1;
          sb.push_back(u);
        end
      end
      cyc();
      if (popped) instr_valid_i = 1'b0;
      n_cyc++;
    end
    checks++;
    if (n_gen != 150 || instr_valid_i || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_timeout got gen=%0d pending=%0b outstanding=%0d want 150 0 0", n_gen, instr_valid_i, sb.size());
    end
    instr_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_emul8();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
